ws2812b_in_decoder: RTL and testbench
=====================================

WS2812B_IN_DECODER -- requirements
Module: ws2812b_in_decoder

Interface
REQ-001 Parameter CYCLES_SHORT, default 6, nominal high time of a 0-bit in clk cycles.
REQ-002 Parameter CYCLES_LONG, default 13, nominal high time of a 1-bit in clk cycles.
REQ-003 Parameter CYCLES_RESET, default 850, minimum low time that ends a frame (~50 us at 17 MHz).
REQ-004 Parameter CYCLES_MAX_HIGH, default 26, longest legal high time; longer is an error.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 ws2812b_data  input  1  asynchronous serial line from a WS2812B stripe or transmitter.
REQ-008 pixel_data  output  24  received pixel, first-received bit at [23] (GRB wire order kept).
REQ-009 pixel_index  output  16  position of pixel_data within its frame, first pixel 0.
REQ-010 pixel_valid  output  1  pixel_data/pixel_index hold a pixel not yet consumed.
REQ-011 pixel_ready  input  1  consumer accepts pixel when high together with pixel_valid.
REQ-012 frame_done  output  1  one-cycle pulse at detected end of frame.
REQ-013 error_flags  output  3  sticky: [0] overrun, [1] high pulse too long, [2] partial pixel at frame end.
REQ-014 clear_errors  input  1  clears error_flags on the following edge.

Function
REQ-015 ws2812b_data SHALL pass a 2-FF synchronizer; all timing below refers to the synchronized signal s, edges detected against its registered previous value.
REQ-016 Threshold THR SHALL be (CYCLES_SHORT+CYCLES_LONG)/2, integer truncation; counter 16 bits, saturating at 0xFFFF, never wrapping.
REQ-017 FSM states SYNC, IDLE, HIGH, LOW.
REQ-018 SYNC: count consecutive low cycles of s; high restarts count; count reaching CYCLES_RESET -> IDLE, no frame_done.
REQ-019 IDLE: rising edge of s -> HIGH with counter=1, bit_count=0, pixel_count=0.
REQ-020 HIGH: counter increments each cycle s high; falling edge classifies: counter<THR -> bit 0; THR<=counter<=CYCLES_MAX_HIGH -> bit 1; then -> LOW with counter=1.
REQ-021 HIGH with counter exceeding CYCLES_MAX_HIGH SHALL set error_flags[1], discard shift register and bit_count, -> SYNC.
REQ-022 Accepted bits shift MSB-first into a 24-bit register; bit_count 0..23.
REQ-023 The 24th bit SHALL, in the same cycle as classification, load the output buffer with the full word and pixel_index=pixel_count, set pixel_valid, increment pixel_count, bit_count->0.
REQ-024 Buffer full (pixel_valid=1 and pixel_ready=0) when a 24th bit completes: new pixel dropped, error_flags[0] set, pixel_count still increments, held pixel unchanged.
REQ-025 pixel_valid=1 and pixel_ready=1 on a cycle: pixel_valid clears next cycle, unless a new pixel loads that same cycle, in which case new pixel loads, pixel_valid stays 1, no overrun.
REQ-026 LOW: counter increments while s low; rising edge -> HIGH with counter=1; counter reaching CYCLES_RESET -> frame_done pulse, -> IDLE.
REQ-027 At frame end with bit_count!=0: error_flags[2] set, partial bits discarded.
REQ-028 Latency: pixel_valid rises 4 clk cycles after ws2812b_data falls on the 24th bit (2 sync + edge detect + output register).
REQ-029 pixel_count saturates at 0xFFFF within a frame.
REQ-030 clear_errors and a new error event in the same cycle: new error wins (flag set).

Reset
REQ-031 resetn=0 at a rising edge: state SYNC, counter 0, bit_count 0, pixel_count 0, synchronizer cleared to 0.
REQ-032 Outputs in reset: pixel_data 0, pixel_index 0, pixel_valid 0, frame_done 0, error_flags 0.
REQ-033 Reset mid-pixel or mid-frame discards all partial data; decoding resumes only after SYNC satisfied.

Verification
REQ-034 Reset, line low 900 cycles, then 24 bits of 0x00FF81 (high 6/13, period 19), line low 900 -> one pixel 0x00FF81 index 0, one frame_done, error_flags 0.
REQ-035 Three pixels 0x123456, 0xABCDEF, 0x000001, pixel_ready held 1 -> indices 0,1,2 in order, frame_done once after final low of 850 cycles.
REQ-036 Two pixels, pixel_ready held 0 -> first pixel held, error_flags=3'b001; clear_errors pulse -> 3'b000.
REQ-037 High pulse of 30 cycles mid-pixel -> error_flags[1] set, no pixel, next valid frame after 850 low decodes correctly.
REQ-038 12 bits then 900 low -> frame_done, error_flags[2] set, no pixel_valid.
REQ-039 Boundary highs of 8 and 9 cycles -> bits 0 and 1; resetn low during bit 10 -> all outputs 0, no pixel until SYNC completes.

Source files
------------

// File: rtl/ws2812b_in_decoder_if.sv
// Pixel stream handshake between the WS2812B decoder and whatever consumes its pixels.
// The decoder is the master: it presents a pixel with its frame position and holds it
// until the consumer raises pixel_ready.
interface ws2812b_in_decoder_if;
  logic [23:0] pixel_data;
  logic [15:0] pixel_index;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output pixel_data,
    output pixel_index,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_index,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/ws2812b_in_decoder.sv
// WS2812B line receiver: measures high-pulse widths on the serial line and turns them into
// 24-bit GRB pixels, one per 24 bits, with a long low period marking the end of a frame.
// The line is synchronized, then edge-detected through a register stage, so every timing
// measurement below is taken on a uniformly delayed copy of the line.
module ws2812b_in_decoder #(
  parameter int CYCLES_SHORT    = 6,
  parameter int CYCLES_LONG     = 13,
  parameter int CYCLES_RESET    = 850,
  parameter int CYCLES_MAX_HIGH = 26
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ws2812b_data,
  ws2812b_in_decoder_if.master        pix,
  output logic                        frame_done,
  output logic [2:0]                  error_flags,
  input  logic                        clear_errors
);

  // Pulses shorter than the midpoint of the two nominal widths decode as 0.
  localparam int          THR      = (CYCLES_SHORT + CYCLES_LONG) / 2;
  localparam logic [15:0] THR_C    = 16'(THR);
  localparam logic [15:0] MAX_C    = 16'(CYCLES_MAX_HIGH);
  localparam logic [15:0] RESET_C  = 16'(CYCLES_RESET);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t      state;
  logic [15:0] counter;
  logic [4:0]  bit_count;
  logic [15:0] pixel_count;
  logic [22:0] shift_reg;

  logic s_meta;
  logic s_sync;
  logic s_prev;
  logic s_level;
  logic edge_rise;
  logic edge_fall;

  logic [15:0] cnt_inc;
  logic        bit_val;
  logic [23:0] shifted;
  logic        too_long;
  logic        bit_done;
  logic        word_done;
  logic        load;
  logic        overrun;
  logic        frame_end;
  logic        partial;
  logic [2:0]  err_set;

  // Two-flop synchronizer followed by a registered edge detector; s_level is the line
  // delayed to line up with the registered edge flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_meta    <= 1'b0;
      s_sync    <= 1'b0;
      s_prev    <= 1'b0;
      s_level   <= 1'b0;
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
    end else begin
      s_meta    <= ws2812b_data;
      s_sync    <= s_meta;
      s_prev    <= s_sync;
      s_level   <= s_sync;
      edge_rise <= s_sync & ~s_prev;
      edge_fall <= ~s_sync & s_prev;
    end
  end

  // Decode conditions for the current cycle: bit classification, pixel completion,
  // buffer overrun, over-long highs and frame end.
  always_comb begin
    cnt_inc   = (counter == 16'hFFFF) ? counter : counter + 16'd1;
    bit_val   = (counter >= THR_C);
    shifted   = {shift_reg, bit_val};
    too_long  = (state == HIGH) && (counter > MAX_C);
    bit_done  = (state == HIGH) && edge_fall && !too_long;
    word_done = bit_done && (bit_count == 5'd23);
    load      = word_done && (!pix.pixel_valid || pix.pixel_ready);
    overrun   = word_done && !load;
    frame_end = (state == LOW) && !edge_rise && (cnt_inc >= RESET_C);
    partial   = frame_end && (bit_count != 5'd0);
    err_set   = {partial, too_long, overrun};
  end

  // Frame/bit state machine together with the registered pixel, pulse and error outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= SYNC;
      counter         <= 16'd0;
      bit_count       <= 5'd0;
      pixel_count     <= 16'd0;
      shift_reg       <= 23'd0;
      pix.pixel_data  <= 24'd0;
      pix.pixel_index <= 16'd0;
      pix.pixel_valid <= 1'b0;
      frame_done      <= 1'b0;
      error_flags     <= 3'd0;
    end else begin
      frame_done  <= frame_end;
      error_flags <= (clear_errors ? 3'd0 : error_flags) | err_set;

      if (load) begin
        pix.pixel_data  <= shifted;
        pix.pixel_index <= pixel_count;
        pix.pixel_valid <= 1'b1;
      end else if (pix.pixel_ready) begin
        pix.pixel_valid <= 1'b0;
      end

      case (state)
        SYNC: begin
          bit_count <= 5'd0;
          shift_reg <= 23'd0;
          if (s_level) begin
            counter <= 16'd0;
          end else begin
            counter <= cnt_inc;
            if (cnt_inc >= RESET_C) begin
              state <= IDLE;
            end
          end
        end
        IDLE: begin
          if (edge_rise) begin
            state       <= HIGH;
            counter     <= 16'd1;
            bit_count   <= 5'd0;
            pixel_count <= 16'd0;
            shift_reg   <= 23'd0;
          end
        end
        HIGH: begin
          if (too_long) begin
            state     <= SYNC;
            counter   <= 16'd0;
            bit_count <= 5'd0;
            shift_reg <= 23'd0;
          end else if (edge_fall) begin
            state     <= LOW;
            counter   <= 16'd1;
            shift_reg <= shifted[22:0];
            if (bit_count == 5'd23) begin
              bit_count   <= 5'd0;
              pixel_count <= (pixel_count == 16'hFFFF) ? pixel_count : pixel_count + 16'd1;
            end else begin
              bit_count <= bit_count + 5'd1;
            end
          end else begin
            counter <= cnt_inc;
          end
        end
        LOW: begin
          if (edge_rise) begin
            state   <= HIGH;
            counter <= 16'd1;
          end else if (frame_end) begin
            state     <= IDLE;
            counter   <= 16'd0;
            bit_count <= 5'd0;
            shift_reg <= 23'd0;
          end else begin
            counter <= cnt_inc;
          end
        end
        default: begin
          state   <= SYNC;
          counter <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_in_decoder.sv
// Directed bench for the WS2812B line decoder: drives hand-built pulse trains and compares
// received pixels, frame pulses and error flags against hand-computed values.
module tb_ws2812b_in_decoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ws2812b_data;
  logic       frame_done;
  logic [2:0] error_flags;
  logic       clear_errors;

  ws2812b_in_decoder_if pix_if ();

  ws2812b_in_decoder dut (
    .clk          (clk),
    .resetn       (resetn),
    .ws2812b_data (ws2812b_data),
    .pix          (pix_if.master),
    .frame_done   (frame_done),
    .error_flags  (error_flags),
    .clear_errors (clear_errors)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  int          assert_count = 0;
  int          fail_count   = 0;
  int          cycle_cnt    = 0;
  int          cap_n        = 0;
  logic [23:0] cap_data [8];
  logic [15:0] cap_idx  [8];
  int          frames       = 0;
  int          valid_rises  = 0;
  int          valid_rise_cycle = 0;
  int          last_fall_cycle  = 0;
  logic        prev_valid   = 1'b0;

  // Count rising edges so latency can be measured in clock cycles.
  always @(posedge clk) cycle_cnt++;

  // Observe outputs mid-cycle: capture handshaken pixels, frame pulses and valid rises.
  always @(negedge clk) begin
    if (pix_if.pixel_valid && pix_if.pixel_ready && cap_n < 8) begin
      cap_data[cap_n] = pix_if.pixel_data;
      cap_idx[cap_n]  = pix_if.pixel_index;
      cap_n++;
    end
    if (frame_done) frames++;
    if (pix_if.pixel_valid && !prev_valid) begin
      valid_rises++;
      valid_rise_cycle = cycle_cnt;
    end
    prev_valid = pix_if.pixel_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_level(input logic v, input int n);
    ws2812b_data = v;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input int hi, input int lo);
    drive_level(1'b1, hi);
    last_fall_cycle = cycle_cnt;
    drive_level(1'b0, lo);
  endtask

  task automatic applyStimulus(input logic [23:0] word);
    for (int i = 23; i >= 0; i--) begin
      if (word[i]) send_bit(13, 6);
      else         send_bit(6, 13);
    end
  endtask

  task automatic clear_monitor();
    cap_n       = 0;
    frames      = 0;
    valid_rises = 0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(posedge clk);
    #2;
    clear_errors = 1'b0;
  endtask

  initial begin
    resetn             = 1'b0;
    ws2812b_data       = 1'b0;
    clear_errors       = 1'b0;
    pix_if.pixel_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    checkOutput("rst_data",  32'(pix_if.pixel_data),  32'h0);
    checkOutput("rst_index", 32'(pix_if.pixel_index), 32'h0);
    checkOutput("rst_valid", 32'(pix_if.pixel_valid), 32'h0);
    checkOutput("rst_frame", 32'(frame_done),         32'h0);
    checkOutput("rst_err",   32'(error_flags),        32'h0);
    resetn = 1'b1;

    $display("[TB] single pixel frame");
    drive_level(1'b0, 900);
    clear_monitor();
    applyStimulus(24'h00FF81);
    drive_level(1'b0, 900);
    checkOutput("p1_count",   32'(cap_n),       32'd1);
    checkOutput("p1_data",    32'(cap_data[0]), 32'h00FF81);
    checkOutput("p1_index",   32'(cap_idx[0]),  32'd0);
    checkOutput("p1_frames",  32'(frames),      32'd1);
    checkOutput("p1_err",     32'(error_flags), 32'h0);
    checkOutput("p1_rises",   32'(valid_rises), 32'd1);
    checkOutput("p1_latency", 32'(valid_rise_cycle - last_fall_cycle), 32'd4);

    $display("[TB] three pixel frame");
    clear_monitor();
    applyStimulus(24'h123456);
    applyStimulus(24'hABCDEF);
    applyStimulus(24'h000001);
    drive_level(1'b0, 800);
    checkOutput("p3_early_frame", 32'(frames), 32'd0);
    checkOutput("p3_count",       32'(cap_n),  32'd3);
    drive_level(1'b0, 100);
    checkOutput("p3_frames", 32'(frames),      32'd1);
    checkOutput("p3_data0",  32'(cap_data[0]), 32'h123456);
    checkOutput("p3_index0", 32'(cap_idx[0]),  32'd0);
    checkOutput("p3_data1",  32'(cap_data[1]), 32'hABCDEF);
    checkOutput("p3_index1", 32'(cap_idx[1]),  32'd1);
    checkOutput("p3_data2",  32'(cap_data[2]), 32'h000001);
    checkOutput("p3_index2", 32'(cap_idx[2]),  32'd2);
    checkOutput("p3_err",    32'(error_flags), 32'h0);

    $display("[TB] overrun with consumer stalled");
    pix_if.pixel_ready = 1'b0;
    clear_monitor();
    applyStimulus(24'hA5A5A5);
    applyStimulus(24'h5A5A5A);
    drive_level(1'b0, 900);
    checkOutput("ovr_valid",  32'(pix_if.pixel_valid), 32'h1);
    checkOutput("ovr_data",   32'(pix_if.pixel_data),  32'hA5A5A5);
    checkOutput("ovr_index",  32'(pix_if.pixel_index), 32'd0);
    checkOutput("ovr_err",    32'(error_flags),        32'h1);
    checkOutput("ovr_frames", 32'(frames),             32'd1);
    pulse_clear();
    checkOutput("ovr_cleared", 32'(error_flags), 32'h0);
    pix_if.pixel_ready = 1'b1;
    drive_level(1'b0, 2);
    checkOutput("ovr_consumed", 32'(pix_if.pixel_valid), 32'h0);
    checkOutput("ovr_cap",      32'(cap_n),              32'd1);

    $display("[TB] over-long high pulse");
    clear_monitor();
    repeat (5) send_bit(13, 6);
    drive_level(1'b1, 30);
    drive_level(1'b0, 900);
    checkOutput("long_err",    32'(error_flags), 32'h2);
    checkOutput("long_cap",    32'(cap_n),       32'd0);
    checkOutput("long_frames", 32'(frames),      32'd0);
    checkOutput("long_rises",  32'(valid_rises), 32'd0);
    pulse_clear();
    applyStimulus(24'h3C3C3C);
    drive_level(1'b0, 900);
    checkOutput("long_next_data",  32'(cap_data[0]), 32'h3C3C3C);
    checkOutput("long_next_index", 32'(cap_idx[0]),  32'd0);
    checkOutput("long_next_frame", 32'(frames),      32'd1);
    checkOutput("long_next_err",   32'(error_flags), 32'h0);

    $display("[TB] partial pixel at frame end");
    clear_monitor();
    for (int i = 0; i < 12; i++) begin
      if (i[0]) send_bit(13, 6);
      else      send_bit(6, 13);
    end
    drive_level(1'b0, 900);
    checkOutput("part_frames", 32'(frames),      32'd1);
    checkOutput("part_err",    32'(error_flags), 32'h4);
    checkOutput("part_rises",  32'(valid_rises), 32'd0);
    pulse_clear();

    $display("[TB] threshold and max-high boundaries");
    clear_monitor();
    begin
      logic [23:0] bword;
      bword = 24'hF0F0F0;
      for (int i = 23; i >= 0; i--) begin
        if (i == 23)        send_bit(26, 13);
        else if (bword[i])  send_bit(9, 10);
        else                send_bit(8, 11);
      end
    end
    drive_level(1'b0, 900);
    checkOutput("bnd_data",   32'(cap_data[0]), 32'hF0F0F0);
    checkOutput("bnd_index",  32'(cap_idx[0]),  32'd0);
    checkOutput("bnd_frames", 32'(frames),      32'd1);
    checkOutput("bnd_err",    32'(error_flags), 32'h0);

    $display("[TB] reset in the middle of a pixel");
    clear_monitor();
    repeat (9) send_bit(13, 6);
    drive_level(1'b1, 5);
    resetn = 1'b0;
    drive_level(1'b1, 3);
    checkOutput("mrst_data",  32'(pix_if.pixel_data),  32'h0);
    checkOutput("mrst_index", 32'(pix_if.pixel_index), 32'h0);
    checkOutput("mrst_valid", 32'(pix_if.pixel_valid), 32'h0);
    checkOutput("mrst_frame", 32'(frame_done),         32'h0);
    checkOutput("mrst_err",   32'(error_flags),        32'h0);
    resetn = 1'b1;
    drive_level(1'b1, 5);
    drive_level(1'b0, 6);
    repeat (14) send_bit(13, 6);
    drive_level(1'b0, 900);
    checkOutput("mrst_rises",  32'(valid_rises), 32'd0);
    checkOutput("mrst_frames", 32'(frames),      32'd0);
    checkOutput("mrst_err2",   32'(error_flags), 32'h0);
    applyStimulus(24'h0F0F0F);
    drive_level(1'b0, 900);
    checkOutput("mrst_next_data",  32'(cap_data[0]), 32'h0F0F0F);
    checkOutput("mrst_next_index", 32'(cap_idx[0]),  32'd0);
    checkOutput("mrst_next_frame", 32'(frames),      32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
